// File: rtl/wb_pkg.sv
// Shared widths and the FIFO entry type for the register-file writeback arbiter.
package wb_pkg;
    localparam int REGS_NUM   = 32;
    localparam int REGS_WIDTH = 32;
    localparam int DEPTH      = 4;
    localparam int AW         = $clog2(REGS_NUM);
    localparam int AW_F       = $clog2(DEPTH);
    localparam int CW         = AW_F + 1;

    typedef struct packed {
        logic                  valid;
        logic [AW-1:0]         addr;
        logic [REGS_WIDTH-1:0] data;
    } wb_entry_t;

    typedef wb_entry_t [DEPTH-1:0] wb_array_t;

    // True when a still-valid buffered entry targets register a.
    function automatic logic addr_pending(input wb_array_t e, input logic [AW-1:0] a);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (e[i].valid && (e[i].addr == a)) hit = 1'b1;
        end
        return hit;
    endfunction
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the execute units, the writeback arbiter and the register file.
interface regfile_wb_arbiter_if;
    import wb_pkg::*;

    logic                  alu_valid;
    logic [AW-1:0]         alu_waddr;
    logic [REGS_WIDTH-1:0] alu_wdata;
    // LSU: a transfer happens on any cycle where lsu_valid && lsu_ready are both high at the rising edge.
    logic                  lsu_valid;
    logic                  lsu_ready;
    logic [AW-1:0]         lsu_waddr;
    logic [REGS_WIDTH-1:0] lsu_wdata;
    logic                  we;
    logic [AW-1:0]         waddr;
    logic [REGS_WIDTH-1:0] wdata;
    logic [AW-1:0]         chk_ra;
    logic [AW-1:0]         chk_rb;
    logic                  busy_ra;
    logic                  busy_rb;
    logic [CW-1:0]         fifo_count;

    modport master (
        output alu_valid, alu_waddr, alu_wdata,
        output lsu_valid, lsu_waddr, lsu_wdata, chk_ra, chk_rb,
        input  lsu_ready, we, waddr, wdata, busy_ra, busy_rb, fifo_count
    );

    modport slave (
        input  alu_valid, alu_waddr, alu_wdata,
        input  lsu_valid, lsu_waddr, lsu_wdata, chk_ra, chk_rb,
        output lsu_ready, we, waddr, wdata, busy_ra, busy_rb, fifo_count
    );
endinterface

// File: rtl/wb_fifo.sv
// Circular buffer of pending LSU writes with kill-by-address; popped and unused slots read as invalid.
module wb_fifo
    import wb_pkg::*;
(
    input  logic          clk,
    input  logic          arstn,
    input  logic          push,
    input  wb_entry_t     push_entry,
    input  logic          pop,
    input  logic          kill_en,
    input  logic [AW-1:0] kill_addr,
    output wb_array_t     entries,
    output wb_entry_t     head,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count
);
    wb_array_t     mem_q, mem_d;
    logic [CW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] rd_ptr_q, rd_ptr_d;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW_F] != rd_ptr_q[AW_F]) &&
                     (wr_ptr_q[AW_F-1:0] == rd_ptr_q[AW_F-1:0]);
    assign count   = wr_ptr_q - rd_ptr_q;
    assign head    = mem_q[rd_ptr_q[AW_F-1:0]];
    assign entries = mem_q;

    // Kill first so a same-cycle push to the killed address lands valid.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (kill_en && (mem_q[i].addr == kill_addr)) mem_d[i].valid = 1'b0;
        end
        if (pop && !empty) begin
            mem_d[rd_ptr_q[AW_F-1:0]].valid = 1'b0;
            rd_ptr_d = rd_ptr_q + CW'(1);
        end
        if (push && !full) begin
            mem_d[wr_ptr_q[AW_F-1:0]] = push_entry;
            wr_ptr_d = wr_ptr_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: ALU has priority, LSU results queue in wb_fifo, busy flags cover RAW hazards.
module regfile_wb_arbiter
    import wb_pkg::*;
(
    input  logic               clk,
    input  logic               arstn,
    regfile_wb_arbiter_if.slave bus
);
    logic                  we_q, we_d;
    logic [AW-1:0]         waddr_q, waddr_d;
    logic [REGS_WIDTH-1:0] wdata_q, wdata_d;

    logic          alu_wr, lsu_push, bypass, fifo_push, pop;
    logic          empty, full;
    wb_entry_t     head, push_entry;
    wb_array_t     entries;
    logic [CW-1:0] count;

    assign alu_wr     = bus.alu_valid && (bus.alu_waddr != '0);
    assign lsu_push   = bus.lsu_valid && !full && (bus.lsu_waddr != '0);
    // An idle port with nothing queued lets the LSU result skip the FIFO.
    assign bypass     = lsu_push && !alu_wr && empty;
    assign fifo_push  = lsu_push && !bypass;
    assign push_entry = '{valid: 1'b1, addr: bus.lsu_waddr, data: bus.lsu_wdata};

    wb_fifo u_fifo (
        .clk        (clk),
        .arstn      (arstn),
        .push       (fifo_push),
        .push_entry (push_entry),
        .pop        (pop),
        .kill_en    (alu_wr),
        .kill_addr  (bus.alu_waddr),
        .entries    (entries),
        .head       (head),
        .empty      (empty),
        .full       (full),
        .count      (count)
    );

    always_comb begin
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        pop     = 1'b0;
        if (alu_wr) begin
            we_d    = 1'b1;
            waddr_d = bus.alu_waddr;
            wdata_d = bus.alu_wdata;
        end else if (!empty) begin
            pop = 1'b1;
            if (head.valid) begin
                we_d    = 1'b1;
                waddr_d = head.addr;
                wdata_d = head.data;
            end
        end else if (bypass) begin
            we_d    = 1'b1;
            waddr_d = bus.lsu_waddr;
            wdata_d = bus.lsu_wdata;
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.we         = we_q;
    assign bus.waddr      = waddr_q;
    assign bus.wdata      = wdata_q;
    assign bus.lsu_ready  = !full;
    assign bus.fifo_count = count;
    assign bus.busy_ra    = (bus.chk_ra != '0) &&
                            (addr_pending(entries, bus.chk_ra) || (we_q && (waddr_q == bus.chk_ra)));
    assign bus.busy_rb    = (bus.chk_rb != '0) &&
                            (addr_pending(entries, bus.chk_rb) || (we_q && (waddr_q == bus.chk_rb)));
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios then random traffic against a queue-based model.
module tb_regfile_wb_arbiter;
    import wb_pkg::*;

    // clock / reset
    logic clk = 1'b0;
    logic arstn;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter dut (
        .clk   (clk),
        .arstn (arstn),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int w7_count = 0;

    // reference model: pending LSU writes in arrival order plus the write-port register
    typedef struct {
        bit          v;
        int unsigned addr;
        logic [31:0] data;
    } m_ent_t;

    m_ent_t      mdl_q[$];
    logic        m_we;
    int unsigned m_waddr;
    logic [31:0] m_wdata;
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic m_busy(input int unsigned a);
        if (a == 0) return 1'b0;
        foreach (mdl_q[i]) if (mdl_q[i].v && mdl_q[i].addr == a) return 1'b1;
        return m_we && (m_waddr == a);
    endfunction

    task automatic model_reset();
        mdl_q.delete();
        m_we    = 1'b0;
        m_waddr = 0;
        m_wdata = '0;
    endtask

    task automatic drive(input bit av, input int unsigned aa, input logic [31:0] ad,
                         input bit lv, input int unsigned la, input logic [31:0] ld);
        bus.alu_valid = av;
        bus.alu_waddr = AW'(aa);
        bus.alu_wdata = ad;
        bus.lsu_valid = lv;
        bus.lsu_waddr = AW'(la);
        bus.lsu_wdata = ld;
    endtask

    task automatic set_chk(input int unsigned ra, input int unsigned rb);
        bus.chk_ra = AW'(ra);
        bus.chk_rb = AW'(rb);
    endtask

    // One clock: compare all outputs with the model, advance the model, cross the rising edge.
    task automatic tick();
        bit     accept, alu_w, consumed;
        m_ent_t h, t;
        #1;
        chk("lsu_ready",  bus.lsu_ready,  mdl_q.size() < DEPTH);
        chk("fifo_count", bus.fifo_count, mdl_q.size());
        chk("we",         bus.we,         m_we);
        chk("waddr",      bus.waddr,      m_waddr);
        chk("wdata",      bus.wdata,      m_wdata);
        chk("busy_ra",    bus.busy_ra,    m_busy(bus.chk_ra));
        chk("busy_rb",    bus.busy_rb,    m_busy(bus.chk_rb));

        accept   = bus.lsu_valid && (mdl_q.size() < DEPTH) && (bus.lsu_waddr != 0);
        alu_w    = bus.alu_valid && (bus.alu_waddr != 0);
        consumed = 1'b0;
        if (alu_w) begin
            for (int i = 0; i < mdl_q.size(); i++) begin
                if (mdl_q[i].addr == bus.alu_waddr) begin
                    t = mdl_q[i];
                    t.v = 1'b0;
                    mdl_q[i] = t;
                end
            end
            m_we = 1'b1; m_waddr = bus.alu_waddr; m_wdata = bus.alu_wdata;
        end else if (mdl_q.size() > 0) begin
            h = mdl_q.pop_front();
            m_we = h.v;
            if (h.v) begin m_waddr = h.addr; m_wdata = h.data; end
        end else if (accept) begin
            consumed = 1'b1;
            m_we = 1'b1; m_waddr = bus.lsu_waddr; m_wdata = bus.lsu_wdata;
        end else begin
            m_we = 1'b0;
        end
        if (accept && !consumed) begin
            t.v = 1'b1; t.addr = bus.lsu_waddr; t.data = bus.lsu_wdata;
            mdl_q.push_back(t);
        end

        @(posedge clk);
        @(negedge clk);
        if (bus.we && bus.waddr == 7) w7_count++;
    endtask

    task automatic apply_reset_now();
        #2 arstn = 1'b0;
        #1;
        chk("rst_we",         bus.we,         1'b0);
        chk("rst_fifo_count", bus.fifo_count, 0);
        chk("rst_lsu_ready",  bus.lsu_ready,  1'b1);
        model_reset();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        arstn = 1'b1;
    endtask

    initial begin
        arstn = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        set_chk(0, 0);
        model_reset();
        #2;
        chk("reset_we",         bus.we,         1'b0);
        chk("reset_waddr",      bus.waddr,      0);
        chk("reset_wdata",      bus.wdata,      0);
        chk("reset_fifo_count", bus.fifo_count, 0);
        chk("reset_lsu_ready",  bus.lsu_ready,  1'b1);
        @(negedge clk);
        arstn = 1'b1;
        tick();

        // single ALU write
        drive(1, 5, 32'hA5A5, 0, 0, 0);
        tick();
        chk("t1_we",    bus.we,    1'b1);
        chk("t1_waddr", bus.waddr, 5);
        chk("t1_wdata", bus.wdata, 32'hA5A5);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        chk("t1_we_off", bus.we, 1'b0);

        // fill the FIFO behind a busy ALU, then drain in order
        for (int i = 1; i <= 4; i++) begin
            drive(1, 9, 32'h900 + i, 1, i, 32'h100 + i);
            tick();
        end
        chk("t2_count_full", bus.fifo_count, 4);
        chk("t2_not_ready",  bus.lsu_ready,  1'b0);
        exp_q = '{32'd1, 32'd2, 32'd3, 32'd4};
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_drain_we",    bus.we,    1'b1);
            chk("t2_drain_waddr", bus.waddr, exp_q.pop_front());
        end
        chk("t2_count_empty", bus.fifo_count, 0);

        // ALU write kills an older buffered write to the same register
        w7_count = 0;
        drive(1, 9, 32'h9, 1, 7, 32'h77);
        tick();
        drive(1, 7, 32'h11, 0, 0, 0);
        tick();
        chk("t3_wdata", bus.wdata, 32'h11);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        chk("t3_killed_no_we", bus.we, 1'b0);
        tick();
        chk("t3_one_write", w7_count, 1);
        chk("t3_count",     bus.fifo_count, 0);

        // r0 on both sources
        drive(1, 0, 32'h5, 1, 0, 32'h9);
        tick();
        chk("t4_we",    bus.we,         1'b0);
        chk("t4_count", bus.fifo_count, 0);

        // idle port and empty FIFO: LSU result lands with ALU latency
        drive(0, 0, 0, 1, 6, 32'h66);
        tick();
        chk("lat_we",    bus.we,    1'b1);
        chk("lat_waddr", bus.waddr, 6);
        drive(0, 0, 0, 0, 0, 0);
        tick();

        // busy flags
        drive(1, 9, 32'h1, 1, 3, 32'h33);
        tick();
        set_chk(3, 0);
        drive(1, 9, 32'h2, 0, 0, 0);
        #1;
        chk("t5_busy_ra", bus.busy_ra, 1'b1);
        chk("t5_busy_rb", bus.busy_rb, 1'b0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        #1;
        chk("t5_busy_ra_clear", bus.busy_ra, 1'b0);
        set_chk(0, 0);

        // reset mid-operation
        for (int i = 0; i < 3; i++) begin
            drive(1, 9, 32'h9, 1, 10 + i, 32'h200 + i);
            tick();
        end
        chk("t6_pre_count", bus.fifo_count, 3);
        chk("t6_pre_we",    bus.we,         1'b1);
        apply_reset_now();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_no_write", bus.we, 1'b0);
        end

        // random traffic with one reset in the middle
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 9) < 5, $urandom_range(0, 7), $urandom,
                  $urandom_range(0, 9) < 6, $urandom_range(0, 7), $urandom);
            set_chk($urandom_range(0, 7), $urandom_range(0, 7));
            tick();
            if (c == 200) apply_reset_now();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
